// File: rtl/not_serial_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// not_serial_pkg
// Shared types and constants for the serial one's-complement arbiter.
//   - state_e     : controller states (IDLE / RUN / DONE)
//   - SLICE_W     : width of the single shared inverter slice
//   - nbeats()    : number of slice steps needed for a DATA_W operand
//   - beat_cnt_w(): beat counter width, never less than 1 bit
// Build option: NOT_SERIAL_WIDE_EN selects a 16-bit slice instead of 8-bit.
// ---------------------------------------------------------------------------
package not_serial_pkg;

`ifdef NOT_SERIAL_WIDE_EN
    localparam int SLICE_W = 16;
`else
    localparam int SLICE_W = 8;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int nbeats(input int data_w);
        return data_w / SLICE_W;
    endfunction

    // A single-beat build still needs a 1-bit counter to keep the RTL uniform.
    function automatic int beat_cnt_w(input int data_w);
        if (nbeats(data_w) <= 1) begin
            return 1;
        end else begin
            return $clog2(nbeats(data_w));
        end
    endfunction

endpackage

// File: rtl/not_serial_arbiter_if.sv
// ---------------------------------------------------------------------------
// not_serial_arbiter_if
// Bundles the two requester channels, the result channel and the busy flag.
//   in0_valid/in0_data/in0_ready : requester 0 operand handshake
//   in1_valid/in1_data/in1_ready : requester 1 operand handshake
//   out_valid/out_data/out_id/out_ready : tagged result handshake
//   busy : arbiter is working on or holding a result
// Modports: slave = the arbiter, master = the requesters/consumer side.
// ---------------------------------------------------------------------------
interface not_serial_arbiter_if #(
    parameter int DATA_W = 32
) ();

    logic              in0_valid;
    logic [DATA_W-1:0] in0_data;
    logic              in0_ready;
    logic              in1_valid;
    logic [DATA_W-1:0] in1_data;
    logic              in1_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_id;
    logic              out_ready;
    logic              busy;

    modport slave (
        input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
        output in0_ready, in1_ready, out_valid, out_data, out_id, busy
    );

    modport master (
        output in0_valid, in0_data, in1_valid, in1_data, out_ready,
        input  in0_ready, in1_ready, out_valid, out_data, out_id, busy
    );

endinterface

// File: rtl/not_slice.sv
// ---------------------------------------------------------------------------
// not_slice
// The one shared bitwise inverter slice. Purely combinational.
//   a : W-bit slice of the operand
//   y : bitwise complement of a
// ---------------------------------------------------------------------------
module not_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    assign y = ~a;

endmodule

// File: rtl/not_serial_arbiter.sv
// ---------------------------------------------------------------------------
// not_serial_arbiter
// Two requesters share one narrow inverter slice. An accepted operand is
// complemented one slice per clock, then presented as a tagged result that
// is held until the consumer takes it. Ties are broken round-robin.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : not_serial_arbiter_if.slave (request, result and busy signals)
// Build option: NOT_SERIAL_WIDE_EN (16-bit slice, half the beats).
// ---------------------------------------------------------------------------
module not_serial_arbiter
    import not_serial_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    not_serial_arbiter_if.slave   bus
);

    localparam int                NBEATS    = nbeats(DATA_W);
    localparam int                BEAT_W    = beat_cnt_w(DATA_W);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q,  beat_d;
    logic [DATA_W-1:0]   op_q,    op_d;
    logic [DATA_W-1:0]   res_q,   res_d;
    logic                id_q,    id_d;
    logic                last_q,  last_d;

    logic                grant_s;
    logic                gnt_any_s;
    logic                in0_ready_s;
    logic                in1_ready_s;
    logic                accept_s;
    logic [SLICE_W-1:0]  slice_in_s;
    logic [SLICE_W-1:0]  slice_out_s;

    // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        gnt_any_s = bus.in0_valid | bus.in1_valid;
        if (bus.in0_valid && bus.in1_valid) begin
            grant_s = ~last_q;
        end else if (bus.in1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        in0_ready_s = (state_q == IDLE) && gnt_any_s && (grant_s == 1'b0);
        in1_ready_s = (state_q == IDLE) && gnt_any_s && (grant_s == 1'b1);
        accept_s    = (in0_ready_s && bus.in0_valid) || (in1_ready_s && bus.in1_valid);
    end

    // Route the current beat's operand slice into the shared inverter.
    always_comb begin
        slice_in_s = op_q[int'(beat_q) * SLICE_W +: SLICE_W];
    end

    not_slice #(
        .W (SLICE_W)
    ) u_not_slice (
        .a (slice_in_s),
        .y (slice_out_s)
    );

    // Next-state and datapath updates for the IDLE/RUN/DONE controller.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        op_d    = op_q;
        res_d   = res_q;
        id_d    = id_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    op_d    = grant_s ? bus.in1_data : bus.in0_data;
                    id_d    = grant_s;
                    last_d  = grant_s;
                    beat_d  = {BEAT_W{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                res_d[int'(beat_q) * SLICE_W +: SLICE_W] = slice_out_s;
                if (beat_q == LAST_BEAT) begin
                    beat_d  = {BEAT_W{1'b0}};
                    state_d = DONE;
                end else begin
                    beat_d  = beat_q + BEAT_W'(1);
                    state_d = RUN;
                end
            end
            DONE: begin
                // Returning to IDLE takes an edge of its own, so the next
                // accept is always at least one cycle after the transfer.
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller and datapath registers; last resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= {BEAT_W{1'b0}};
            op_q    <= {DATA_W{1'b0}};
            res_q   <= {DATA_W{1'b0}};
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            op_q    <= op_d;
            res_q   <= res_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    assign bus.in0_ready = in0_ready_s;
    assign bus.in1_ready = in1_ready_s;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = res_q;
    assign bus.out_id    = id_q;
    assign bus.busy      = (state_q != IDLE);

endmodule
